// File: rtl/core_pkg.sv
// rtl/core_pkg.sv - shared RV32I core encodings and the decode-to-execute control bundle
package core_pkg;

  // Load type encodings; LD_NONE marks a non-load instruction.
  localparam logic [2:0] LD_NONE = 3'b000;
  localparam logic [2:0] LB      = 3'b001;
  localparam logic [2:0] LW      = 3'b010;
  localparam logic [2:0] LH      = 3'b011;
  localparam logic [2:0] LBU     = 3'b100;
  localparam logic [2:0] LHU     = 3'b101;

  // Store type encodings; ST_NONE marks a non-store instruction.
  localparam logic [1:0] ST_NONE = 2'b00;
  localparam logic [1:0] SB      = 2'b01;
  localparam logic [1:0] SW      = 2'b10;
  localparam logic [1:0] SH      = 2'b11;

  // ALU operations.
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_XOR  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;

  // Control fields that must all be zero for a bubble.
  typedef struct packed {
    logic       reg_write;
    logic [2:0] mem_load;
    logic [1:0] mem_store;
    logic       branch;
    logic       jump;
    logic       valid;
  } de_ctrl_t;

  localparam de_ctrl_t BUBBLE = '0;

  function automatic logic is_load(input logic [2:0] ld_type);
    return ld_type != LD_NONE;
  endfunction

endpackage

// File: rtl/load_use_detect.sv
// rtl/load_use_detect.sv - load-use hazard detection against loads in E and M
module load_use_detect
  import core_pkg::*;
(
  input  logic       validD_i,
  input  logic [4:0] rs1D_i,
  input  logic [4:0] rs2D_i,
  input  logic       use_rs1D_i,
  input  logic       use_rs2D_i,
  input  logic       validE_i,
  input  logic [2:0] mem_loadE_i,
  input  logic       reg_writeE_i,
  input  logic [4:0] rdE_i,
  input  logic [2:0] mem_loadM_i,
  input  logic       reg_writeM_i,
  input  logic [4:0] rdM_i,
  output logic       hazE_o,
  output logic       hazM_o,
  output logic       hazard_o
);

  logic srcE_match;
  logic srcM_match;

  // x0 is never a producer, and unused sources never match.
  assign srcE_match = (rdE_i != 5'd0) &&
                      ((use_rs1D_i && (rs1D_i == rdE_i)) || (use_rs2D_i && (rs2D_i == rdE_i)));
  assign srcM_match = (rdM_i != 5'd0) &&
                      ((use_rs1D_i && (rs1D_i == rdM_i)) || (use_rs2D_i && (rs2D_i == rdM_i)));

  // M carries no valid bit; a bubble in M is recognised by its zero load type.
  assign hazE_o   = validE_i && is_load(mem_loadE_i) && reg_writeE_i && srcE_match;
  assign hazM_o   = is_load(mem_loadM_i) && reg_writeM_i && srcM_match;
  assign hazard_o = validD_i && (hazE_o || hazM_o);

endmodule

// File: rtl/de_stage_reg.sv
// rtl/de_stage_reg.sv - decode-to-execute pipeline register with load-use stall and bubble counter
module de_stage_reg
  import core_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int ALUC_W = 4,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [4:0]        rs1D,
  input  logic [4:0]        rs2D,
  input  logic              use_rs1D,
  input  logic              use_rs2D,
  input  logic [XLEN-1:0]   reg_data1D,
  input  logic [XLEN-1:0]   reg_data2D,
  input  logic [XLEN-1:0]   immD,
  input  logic [XLEN-1:0]   pcD,
  input  logic [4:0]        rdD,
  input  logic [ALUC_W-1:0] alu_ctrlD,
  input  logic [2:0]        mem_loadD,
  input  logic [1:0]        mem_storeD,
  input  logic              reg_writeD,
  input  logic              branchD,
  input  logic              jumpD,
  input  logic              validD,
  input  logic [4:0]        rdM,
  input  logic [2:0]        mem_loadM,
  input  logic              reg_writeM,
  input  logic              flushE,
  input  logic              holdE,
  output logic [4:0]        rs1E,
  output logic [4:0]        rs2E,
  output logic [XLEN-1:0]   reg_data1E,
  output logic [XLEN-1:0]   reg_data2E,
  output logic [XLEN-1:0]   immE,
  output logic [XLEN-1:0]   pcE,
  output logic [4:0]        rdE,
  output logic [ALUC_W-1:0] alu_ctrlE,
  output logic [2:0]        mem_loadE,
  output logic [1:0]        mem_storeE,
  output logic              reg_writeE,
  output logic              branchE,
  output logic              jumpE,
  output logic              validE,
  output logic              stallD,
  output logic [CNT_W-1:0]  bubble_cnt
);

  de_ctrl_t          ctrl_q, ctrl_d, ctrl_in;
  logic [4:0]        rs1_q, rs1_d, rs2_q, rs2_d, rd_q, rd_d;
  logic [XLEN-1:0]   data1_q, data1_d, data2_q, data2_d, imm_q, imm_d, pc_q, pc_d;
  logic [ALUC_W-1:0] alu_q, alu_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              hazE, hazM, hazard;
  logic              kill, advance;

  load_use_detect u_detect (
    .validD_i     (validD),
    .rs1D_i       (rs1D),
    .rs2D_i       (rs2D),
    .use_rs1D_i   (use_rs1D),
    .use_rs2D_i   (use_rs2D),
    .validE_i     (ctrl_q.valid),
    .mem_loadE_i  (ctrl_q.mem_load),
    .reg_writeE_i (ctrl_q.reg_write),
    .rdE_i        (rd_q),
    .mem_loadM_i  (mem_loadM),
    .reg_writeM_i (reg_writeM),
    .rdM_i        (rdM),
    .hazE_o       (hazE),
    .hazM_o       (hazM),
    .hazard_o     (hazard)
  );

  // Flush overrides everything; hold overrides a hazard.
  assign stallD  = (hazard || holdE) && !flushE;
  assign kill    = flushE || (!holdE && hazard);
  assign advance = !flushE && !holdE && !hazard;

  assign ctrl_in = '{reg_write: reg_writeD, mem_load: mem_loadD, mem_store: mem_storeD,
                     branch: branchD, jump: jumpD, valid: validD};

  // Next E contents: zero on flush or hazard bubble, keep on hold, else take D.
  always_comb begin
    ctrl_d  = ctrl_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    rd_d    = rd_q;
    data1_d = data1_q;
    data2_d = data2_q;
    imm_d   = imm_q;
    pc_d    = pc_q;
    alu_d   = alu_q;
    cnt_d   = cnt_q;
    if (kill) begin
      ctrl_d  = BUBBLE;
      rs1_d   = '0;
      rs2_d   = '0;
      rd_d    = '0;
      data1_d = '0;
      data2_d = '0;
      imm_d   = '0;
      pc_d    = '0;
      alu_d   = '0;
    end else if (advance) begin
      ctrl_d  = validD ? ctrl_in : BUBBLE;
      rs1_d   = rs1D;
      rs2_d   = rs2D;
      rd_d    = rdD;
      data1_d = reg_data1D;
      data2_d = reg_data2D;
      imm_d   = immD;
      pc_d    = pcD;
      alu_d   = alu_ctrlD;
    end
    if (!flushE && !holdE && hazard) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // E register and bubble counter; reset loads a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ctrl_q  <= BUBBLE;
      rs1_q   <= '0;
      rs2_q   <= '0;
      rd_q    <= '0;
      data1_q <= '0;
      data2_q <= '0;
      imm_q   <= '0;
      pc_q    <= '0;
      alu_q   <= '0;
      cnt_q   <= '0;
    end else begin
      ctrl_q  <= ctrl_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      rd_q    <= rd_d;
      data1_q <= data1_d;
      data2_q <= data2_d;
      imm_q   <= imm_d;
      pc_q    <= pc_d;
      alu_q   <= alu_d;
      cnt_q   <= cnt_d;
    end
  end

  assign rs1E       = rs1_q;
  assign rs2E       = rs2_q;
  assign reg_data1E = data1_q;
  assign reg_data2E = data2_q;
  assign immE       = imm_q;
  assign pcE        = pc_q;
  assign rdE        = rd_q;
  assign alu_ctrlE  = alu_q;
  assign mem_loadE  = ctrl_q.mem_load;
  assign mem_storeE = ctrl_q.mem_store;
  assign reg_writeE = ctrl_q.reg_write;
  assign branchE    = ctrl_q.branch;
  assign jumpE      = ctrl_q.jump;
  assign validE     = ctrl_q.valid;
  assign bubble_cnt = cnt_q;

endmodule

// File: tb/tb_de_stage_reg.sv
// tb/tb_de_stage_reg.sv - self-checking bench for de_stage_reg
module tb_de_stage_reg;
  import core_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [4:0]  rs1D, rs2D, rdD, rdM;
  logic        use_rs1D, use_rs2D;
  logic [31:0] reg_data1D, reg_data2D, immD, pcD;
  logic [3:0]  alu_ctrlD;
  logic [2:0]  mem_loadD, mem_loadM;
  logic [1:0]  mem_storeD;
  logic        reg_writeD, branchD, jumpD, validD, reg_writeM, flushE, holdE;

  logic [4:0]  rs1E, rs2E, rdE;
  logic [31:0] reg_data1E, reg_data2E, immE, pcE;
  logic [3:0]  alu_ctrlE;
  logic [2:0]  mem_loadE;
  logic [1:0]  mem_storeE;
  logic        reg_writeE, branchE, jumpE, validE, stallD;
  logic [31:0] bubble_cnt;

  logic [4:0]  n_rs1E, n_rs2E, n_rdE;
  logic [31:0] n_reg_data1E, n_reg_data2E, n_immE, n_pcE;
  logic [3:0]  n_alu_ctrlE;
  logic [2:0]  n_mem_loadE;
  logic [1:0]  n_mem_storeE;
  logic        n_reg_writeE, n_branchE, n_jumpE, n_validE, n_stallD;
  logic [1:0]  n_bubble_cnt;

  de_stage_reg #(.XLEN(32), .ALUC_W(4), .CNT_W(32)) dut (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .reg_data1D(reg_data1D), .reg_data2D(reg_data2D), .immD(immD), .pcD(pcD), .rdD(rdD),
    .alu_ctrlD(alu_ctrlD), .mem_loadD(mem_loadD), .mem_storeD(mem_storeD), .reg_writeD(reg_writeD),
    .branchD(branchD), .jumpD(jumpD), .validD(validD), .rdM(rdM), .mem_loadM(mem_loadM),
    .reg_writeM(reg_writeM), .flushE(flushE), .holdE(holdE),
    .rs1E(rs1E), .rs2E(rs2E), .reg_data1E(reg_data1E), .reg_data2E(reg_data2E), .immE(immE),
    .pcE(pcE), .rdE(rdE), .alu_ctrlE(alu_ctrlE), .mem_loadE(mem_loadE), .mem_storeE(mem_storeE),
    .reg_writeE(reg_writeE), .branchE(branchE), .jumpE(jumpE), .validE(validE),
    .stallD(stallD), .bubble_cnt(bubble_cnt)
  );

  // Narrow-counter instance: exercises the counter wrap in a few bubbles.
  de_stage_reg #(.XLEN(32), .ALUC_W(4), .CNT_W(2)) dut_n (
    .clk(clk), .rst(rst), .rs1D(rs1D), .rs2D(rs2D), .use_rs1D(use_rs1D), .use_rs2D(use_rs2D),
    .reg_data1D(reg_data1D), .reg_data2D(reg_data2D), .immD(immD), .pcD(pcD), .rdD(rdD),
    .alu_ctrlD(alu_ctrlD), .mem_loadD(mem_loadD), .mem_storeD(mem_storeD), .reg_writeD(reg_writeD),
    .branchD(branchD), .jumpD(jumpD), .validD(validD), .rdM(rdM), .mem_loadM(mem_loadM),
    .reg_writeM(reg_writeM), .flushE(flushE), .holdE(holdE),
    .rs1E(n_rs1E), .rs2E(n_rs2E), .reg_data1E(n_reg_data1E), .reg_data2E(n_reg_data2E),
    .immE(n_immE), .pcE(n_pcE), .rdE(n_rdE), .alu_ctrlE(n_alu_ctrlE), .mem_loadE(n_mem_loadE),
    .mem_storeE(n_mem_storeE), .reg_writeE(n_reg_writeE), .branchE(n_branchE), .jumpE(n_jumpE),
    .validE(n_validE), .stallD(n_stallD), .bubble_cnt(n_bubble_cnt)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference view of the E slot, as an instruction record.
  typedef struct {
    logic [4:0]  rs1, rs2, rd;
    logic [31:0] d1, d2, imm, pc;
    logic [3:0]  alu;
    logic [2:0]  ld;
    logic [1:0]  st;
    logic        rw, br, jp, v;
  } e_t;

  e_t          m;
  longint      m_cnt;
  logic [31:0] saved_d1;
  longint      saved_cnt;

  function automatic e_t empty_slot();
    e_t z;
    z = '{rs1: 0, rs2: 0, rd: 0, d1: 0, d2: 0, imm: 0, pc: 0, alu: 0, ld: 0, st: 0,
          rw: 0, br: 0, jp: 0, v: 0};
    return z;
  endfunction

  function automatic bit reads(input logic [4:0] r);
    return (r != 0) && ((use_rs1D && rs1D == r) || (use_rs2D && rs2D == r));
  endfunction

  function automatic bit exp_hazard();
    bit from_e, from_m;
    from_e = m.v && (m.ld != LD_NONE) && m.rw && reads(m.rd);
    from_m = (mem_loadM != LD_NONE) && reg_writeM && reads(rdM);
    return validD && (from_e || from_m);
  endfunction

  function automatic bit exp_stall();
    return (exp_hazard() || holdE) && !flushE;
  endfunction

  function automatic logic [255:0] model_vec();
    return {100'd0, m.rs1, m.rs2, m.d1, m.d2, m.imm, m.pc, m.rd, m.alu, m.ld, m.st, m.rw, m.br, m.jp, m.v};
  endfunction

  task automatic model_edge(input bit hz);
    if (rst) begin
      m = empty_slot();
      m_cnt = 0;
    end else if (flushE) begin
      m = empty_slot();
    end else if (holdE) begin
      m = m;
    end else if (hz) begin
      m = empty_slot();
      m_cnt = m_cnt + 1;
    end else begin
      m.rs1 = rs1D; m.rs2 = rs2D; m.rd = rdD; m.d1 = reg_data1D; m.d2 = reg_data2D;
      m.imm = immD; m.pc = pcD; m.alu = alu_ctrlD;
      m.ld = validD ? mem_loadD : 3'd0;
      m.st = validD ? mem_storeD : 2'd0;
      m.rw = validD && reg_writeD;
      m.br = validD && branchD;
      m.jp = validD && jumpD;
      m.v  = validD;
    end
  endtask

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      $error("check %s differs", tag);
    end
  endtask

  task automatic step(input string tag);
    bit hz;
    #1;
    hz = exp_hazard();
    chk({tag, ".stallD"}, 256'(stallD), 256'(exp_stall()));
    @(posedge clk);
    model_edge(hz);
    #1;
    chk({tag, ".E"}, {100'd0, rs1E, rs2E, reg_data1E, reg_data2E, immE, pcE, rdE, alu_ctrlE,
                      mem_loadE, mem_storeE, reg_writeE, branchE, jumpE, validE}, model_vec());
    chk({tag, ".cnt"}, 256'(bubble_cnt), 256'(m_cnt[31:0]));
    chk({tag, ".nE"}, {100'd0, n_rs1E, n_rs2E, n_reg_data1E, n_reg_data2E, n_immE, n_pcE, n_rdE,
                       n_alu_ctrlE, n_mem_loadE, n_mem_storeE, n_reg_writeE, n_branchE, n_jumpE,
                       n_validE}, model_vec());
    chk({tag, ".ncnt"}, 256'(n_bubble_cnt), 256'(m_cnt[1:0]));
  endtask

  task automatic clear_inputs();
    rs1D = 0; rs2D = 0; use_rs1D = 0; use_rs2D = 0; reg_data1D = 0; reg_data2D = 0;
    immD = 0; pcD = 0; rdD = 0; alu_ctrlD = 0; mem_loadD = 0; mem_storeD = 0;
    reg_writeD = 0; branchD = 0; jumpD = 0; validD = 0;
    rdM = 0; mem_loadM = 0; reg_writeM = 0; flushE = 0; holdE = 0;
  endtask

  task automatic drive_lw_x5();
    clear_inputs();
    validD = 1; rdD = 5; mem_loadD = LW; reg_writeD = 1; rs1D = 2; use_rs1D = 1;
    immD = $urandom; pcD = 32'h100; alu_ctrlD = ALU_ADD;
  endtask

  task automatic drive_add_x6_x5_x1();
    clear_inputs();
    validD = 1; rs1D = 5; rs2D = 1; use_rs1D = 1; use_rs2D = 1; rdD = 6; reg_writeD = 1;
    alu_ctrlD = ALU_ADD; reg_data1D = $urandom; reg_data2D = $urandom; pcD = 32'h104;
  endtask

  function automatic logic [4:0] rreg();
    case ($urandom_range(3))
      0: return 5'd0;
      1: return 5'd5;
      2: return 5'd7;
      default: return 5'($urandom);
    endcase
  endfunction

  initial begin
    m = empty_slot();
    m_cnt = 0;
    clear_inputs();

    rst = 1;
    step("reset");
    chk("reset.validE", 256'(validE), 256'(0));
    chk("reset.bubble_cnt", 256'(bubble_cnt), 256'(0));
    rst = 0;

    // Load in E, then in M: two bubbles before the add proceeds.
    drive_lw_x5();
    step("lw_in");
    drive_add_x6_x5_x1();
    saved_d1 = reg_data1D;
    step("lu_e1");
    chk("lu_e1.validE", 256'(validE), 256'(0));
    chk("lu_e1.bubble_cnt", 256'(bubble_cnt), 256'(1));
    rdM = 5; mem_loadM = LW; reg_writeM = 1;
    step("lu_e2");
    chk("lu_e2.validE", 256'(validE), 256'(0));
    chk("lu_e2.bubble_cnt", 256'(bubble_cnt), 256'(2));
    rdM = 0; mem_loadM = 0; reg_writeM = 0;
    step("lu_pass");
    chk("lu_pass.reg_data1E", 256'(reg_data1E), 256'(saved_d1));
    chk("lu_pass.validE", 256'(validE), 256'(1));

    // Load only in M: a single bubble.
    clear_inputs();
    validD = 1; rs1D = 3; rs2D = 7; use_rs1D = 1; use_rs2D = 1; rdD = 9; reg_writeD = 1;
    reg_data2D = $urandom;
    rdM = 7; mem_loadM = LBU; reg_writeM = 1;
    step("m_only1");
    chk("m_only1.bubble_cnt", 256'(bubble_cnt), 256'(3));
    rdM = 0; mem_loadM = 0; reg_writeM = 0;
    step("m_only2");
    chk("m_only2.validE", 256'(validE), 256'(1));
    chk("m_only2.bubble_cnt", 256'(bubble_cnt), 256'(3));

    // x0 producer and an unused source never stall.
    clear_inputs();
    validD = 1; rdD = 0; mem_loadD = LW; reg_writeD = 1;
    step("lw_x0");
    clear_inputs();
    validD = 1; use_rs1D = 1; use_rs2D = 1; rdD = 8; reg_writeD = 1;
    #1 chk("x0.stallD", 256'(stallD), 256'(0));
    step("x0_read");
    drive_lw_x5();
    step("lw_x5b");
    clear_inputs();
    validD = 1; rs1D = 5; rs2D = 5; rdD = 10; reg_writeD = 1; alu_ctrlD = ALU_LUI; immD = $urandom;
    #1 chk("lui.stallD", 256'(stallD), 256'(0));
    step("lui");
    chk("lui.bubble_cnt", 256'(bubble_cnt), 256'(3));

    // Flush beats hazard.
    drive_lw_x5();
    step("lw_x5c");
    drive_add_x6_x5_x1();
    flushE = 1;
    saved_cnt = m_cnt;
    #1 chk("flush.stallD", 256'(stallD), 256'(0));
    step("flush");
    chk("flush.validE", 256'(validE), 256'(0));
    chk("flush.rdE", 256'(rdE), 256'(0));
    chk("flush.bubble_cnt", 256'(bubble_cnt), 256'(saved_cnt));

    // Hold beats hazard.
    drive_lw_x5();
    step("lw_x5d");
    drive_add_x6_x5_x1();
    holdE = 1;
    #1 chk("hold.stallD", 256'(stallD), 256'(1));
    step("hold");
    chk("hold.rdE", 256'(rdE), 256'(5));
    chk("hold.mem_loadE", 256'(mem_loadE), 256'(LW));
    chk("hold.bubble_cnt", 256'(bubble_cnt), 256'(saved_cnt));

    // Reset with a store in E.
    clear_inputs();
    validD = 1; rs1D = 2; rs2D = 3; use_rs1D = 1; use_rs2D = 1; mem_storeD = SW;
    reg_data2D = $urandom; immD = 32'h10;
    step("sw_in");
    chk("sw_in.mem_storeE", 256'(mem_storeE), 256'(SW));
    rst = 1;
    step("rst_mid");
    chk("rst_mid.mem_storeE", 256'(mem_storeE), 256'(0));
    chk("rst_mid.bubble_cnt", 256'(bubble_cnt), 256'(0));
    rst = 0;

    // Four back-to-back M hazards: the 2-bit counter wraps to 0.
    clear_inputs();
    validD = 1; rs1D = 5; use_rs1D = 1; rdD = 6; reg_writeD = 1;
    rdM = 5; mem_loadM = LW; reg_writeM = 1;
    for (int i = 0; i < 4; i++) step("wrap");
    chk("wrap.bubble_cnt", 256'(bubble_cnt), 256'(4));
    chk("wrap.narrow_cnt", 256'(n_bubble_cnt), 256'(0));

    // Randomised traffic against the reference model.
    for (int i = 0; i < 500; i++) begin
      rst        = ($urandom_range(49) == 0);
      flushE     = ($urandom_range(9) == 0);
      holdE      = ($urandom_range(7) == 0);
      validD     = ($urandom_range(6) != 0);
      rs1D       = rreg();
      rs2D       = rreg();
      rdD        = rreg();
      rdM        = rreg();
      use_rs1D   = 1'($urandom);
      use_rs2D   = 1'($urandom);
      reg_data1D = $urandom;
      reg_data2D = $urandom;
      immD       = $urandom;
      pcD        = $urandom;
      alu_ctrlD  = 4'($urandom);
      mem_loadD  = $urandom_range(1) ? 3'($urandom_range(5)) : LD_NONE;
      mem_storeD = 2'($urandom);
      reg_writeD = 1'($urandom);
      branchD    = 1'($urandom);
      jumpD      = 1'($urandom);
      mem_loadM  = $urandom_range(1) ? 3'($urandom_range(5)) : LD_NONE;
      reg_writeM = 1'($urandom);
      step("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
